// File: rtl/cache_bus_master.sv
// Per-cache memory-bus initiator: optional word-by-word victim write-back, then word-by-word line fill.
// Define BUS_TIMEOUT_EN to add a per-response timeout that aborts into a sticky ERR state.

module cache_bus_master #(
    parameter int WORDWIDTH = 16,
    parameter int ADDRWIDTH = 16,
    parameter int LINEWORDS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           reqValid,
    input  logic                           reqWb,
    input  logic [ADDRWIDTH-1:0]           reqFillAddr,
    input  logic [ADDRWIDTH-1:0]           reqWbAddr,
    input  logic [LINEWORDS*WORDWIDTH-1:0] victimLine,
    output logic                           reqReady,
    output logic [LINEWORDS*WORDWIDTH-1:0] fillLine,
    output logic                           fillDone,
    output logic                           busErr,
    output logic [1:0]                     rwToBus,
    output logic [ADDRWIDTH-1:0]           addrToBus,
    output logic [WORDWIDTH-1:0]           dataToBus,
    input  logic [WORDWIDTH-1:0]           dataFromBus,
    input  logic                           rdEnFromBus,
    input  logic                           wbDoneFromBus
);

    localparam int              IDXW     = $clog2(LINEWORDS);
    localparam int              TAGW     = ADDRWIDTH - IDXW;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LINEWORDS - 1);

    localparam logic [1:0] IDEL = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WT   = 2'b10;

    if (LINEWORDS < 2 || (LINEWORDS & (LINEWORDS - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cache_bus_master: LINEWORDS must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_GAP,
        S_RD_REQ,
        S_RD_GAP,
        S_DONE
`ifdef BUS_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t               state, state_n;
    logic [IDXW-1:0]      idx, idx_n;
    logic [TAGW-1:0]      fill_tag, fill_tag_n;
    logic [TAGW-1:0]      wb_tag, wb_tag_n;
    logic [WORDWIDTH-1:0] victim_q [LINEWORDS];
    logic                 accept;
    logic                 rd_capture;
    logic [1:0]           rw_n;
    logic [ADDRWIDTH-1:0] addr_n;
    logic [WORDWIDTH-1:0] data_n;

`ifdef BUS_TIMEOUT_EN
    localparam int TMOW = $clog2(TIMEOUT + 1);
    logic [TMOW-1:0] tmo, tmo_n;
`endif

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        fill_tag_n = fill_tag;
        wb_tag_n   = wb_tag;
        accept     = 1'b0;
        rd_capture = 1'b0;

        case (state)
            S_IDLE: begin
                if (reqValid) begin
                    accept     = 1'b1;
                    idx_n      = '0;
                    fill_tag_n = reqFillAddr[ADDRWIDTH-1:IDXW];
                    wb_tag_n   = reqWbAddr[ADDRWIDTH-1:IDXW];
                    state_n    = reqWb ? S_WB_REQ : S_RD_REQ;
                end
            end
            S_WB_REQ: begin
                if (wbDoneFromBus) begin
                    state_n = S_WB_GAP;
                end
            end
            S_WB_GAP: begin
                if (idx == LAST_IDX) begin
                    idx_n   = '0;
                    state_n = S_RD_REQ;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = S_WB_REQ;
                end
            end
            S_RD_REQ: begin
                if (rdEnFromBus) begin
                    rd_capture = 1'b1;
                    state_n    = S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                if (idx == LAST_IDX) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = S_RD_REQ;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
`ifdef BUS_TIMEOUT_EN
            S_ERR: begin
                state_n = S_ERR;
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase

`ifdef BUS_TIMEOUT_EN
        // Reload on entry to a REQ state; abort on the cycle the count would hit zero.
        tmo_n = tmo;
        if ((state_n == S_WB_REQ || state_n == S_RD_REQ) && state_n != state) begin
            tmo_n = TMOW'(TIMEOUT);
        end else if ((state == S_WB_REQ || state == S_RD_REQ) && state_n == state) begin
            if (tmo == TMOW'(1)) begin
                state_n = S_ERR;
            end else begin
                tmo_n = tmo - 1'b1;
            end
        end
`endif

        // Outputs are registered, so they are derived from the state being entered.
        rw_n   = IDEL;
        addr_n = addrToBus;
        data_n = dataToBus;
        case (state_n)
            S_WB_REQ: begin
                rw_n   = WT;
                addr_n = {wb_tag_n, idx_n};
                data_n = accept ? victimLine[WORDWIDTH-1:0] : victim_q[idx_n];
            end
            S_RD_REQ: begin
                rw_n   = RD;
                addr_n = {fill_tag_n, idx_n};
            end
            default: begin
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all decisions live in always_comb.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            fill_tag  <= '0;
            wb_tag    <= '0;
            reqReady  <= 1'b1;
            fillDone  <= 1'b0;
            fillLine  <= '0;
            rwToBus   <= IDEL;
            addrToBus <= '0;
            dataToBus <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            fill_tag  <= fill_tag_n;
            wb_tag    <= wb_tag_n;
            reqReady  <= (state_n == S_IDLE);
            fillDone  <= (state_n == S_DONE);
            rwToBus   <= rw_n;
            addrToBus <= addr_n;
            dataToBus <= data_n;
            for (int i = 0; i < LINEWORDS; i++) begin
                if (rd_capture && idx == IDXW'(i)) begin
                    fillLine[i*WORDWIDTH +: WORDWIDTH] <= dataFromBus;
                end
            end
        end
    end

    // NOTE: the victim copy is pure datapath, only read after it is loaded, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LINEWORDS; i++) begin
                victim_q[i] <= victimLine[i*WORDWIDTH +: WORDWIDTH];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo    <= '0;
            busErr <= 1'b0;
        end else begin
            tmo    <= tmo_n;
            busErr <= busErr | (state_n == S_ERR);
        end
    end
`else
    assign busErr = 1'b0;
`endif

endmodule
